// File: rtl/pipe_pkg.sv
// rtl/pipe_pkg.sv - shared constants and types for the pipeline hazard unit
package pipe_pkg;

  // Default register-file address width (32 architectural registers)
  localparam int DEF_REG_ADDR_W = 5;

  // ALU operand source selects
  localparam logic [1:0] FWD_RF  = 2'b00;
  localparam logic [1:0] FWD_WB  = 2'b01;
  localparam logic [1:0] FWD_MEM = 2'b10;

  // Multiply-occupancy FSM encoding
  typedef enum logic {
    MUL_IDLE = 1'b0,
    MUL_BUSY = 1'b1
  } mul_state_e;

endpackage

// File: rtl/hazard_ctrl_unit_if.sv
// rtl/hazard_ctrl_unit_if.sv - pipeline-register view seen by the hazard unit
interface hazard_ctrl_unit_if #(
  parameter int REG_ADDR_W = pipe_pkg::DEF_REG_ADDR_W
);

  // Operand and destination tags from the pipeline registers
  logic [REG_ADDR_W-1:0] rs1_id;
  logic [REG_ADDR_W-1:0] rs2_id;
  logic [REG_ADDR_W-1:0] rs1_ex;
  logic [REG_ADDR_W-1:0] rs2_ex;
  logic [REG_ADDR_W-1:0] rd_ex;
  logic                  mem_read_ex;
  logic                  mul_ex;
  logic                  valid_ex;
  logic [REG_ADDR_W-1:0] rd_mem;
  logic                  reg_write_mem;
  logic [REG_ADDR_W-1:0] rd_wb;
  logic                  reg_write_wb;

  // Controls back to the datapath
  logic [1:0]            fwd_a;
  logic [1:0]            fwd_b;
  logic                  stall_if;
  logic                  stall_id;
  logic                  stall_ex;
  logic                  flush_ex;
  logic                  bubble_mem;
  logic                  mul_busy;
  logic                  mul_done;

  // Pipeline side: supplies tags, consumes controls
  modport master (
    output rs1_id, rs2_id, rs1_ex, rs2_ex, rd_ex, mem_read_ex, mul_ex, valid_ex,
    output rd_mem, reg_write_mem, rd_wb, reg_write_wb,
    input  fwd_a, fwd_b, stall_if, stall_id, stall_ex, flush_ex, bubble_mem,
    input  mul_busy, mul_done
  );

  // Hazard unit side
  modport slave (
    input  rs1_id, rs2_id, rs1_ex, rs2_ex, rd_ex, mem_read_ex, mul_ex, valid_ex,
    input  rd_mem, reg_write_mem, rd_wb, reg_write_wb,
    output fwd_a, fwd_b, stall_if, stall_id, stall_ex, flush_ex, bubble_mem,
    output mul_busy, mul_done
  );

endinterface

// File: rtl/hazard_ctrl_unit_fwd_select.sv
// rtl/hazard_ctrl_unit_fwd_select.sv - per-operand forwarding source priority compare
module fwd_select
  import pipe_pkg::*;
#(
  parameter int REG_ADDR_W = DEF_REG_ADDR_W
) (
  input  logic [REG_ADDR_W-1:0] rs_ex,
  input  logic [REG_ADDR_W-1:0] rd_mem,
  input  logic                  reg_write_mem,
  input  logic [REG_ADDR_W-1:0] rd_wb,
  input  logic                  reg_write_wb,
  output logic [1:0]            fwd
);

  // Youngest producer (EX/MEM) wins; x0 is hardwired zero and never forwarded
  always_comb begin
    fwd = FWD_RF;
    if (reg_write_mem && (rd_mem != '0) && (rd_mem == rs_ex)) begin
      fwd = FWD_MEM;
    end else if (reg_write_wb && (rd_wb != '0) && (rd_wb == rs_ex)) begin
      fwd = FWD_WB;
    end
  end

endmodule

// File: rtl/hazard_ctrl_unit.sv
// rtl/hazard_ctrl_unit.sv - forwarding, load-use stall and multiply-occupancy control
module hazard_ctrl_unit
  import pipe_pkg::*;
#(
  parameter int REG_ADDR_W  = DEF_REG_ADDR_W,
  parameter int MUL_LATENCY = 3,
  parameter int CNT_W       = $clog2(MUL_LATENCY + 1)
) (
  input logic              clk,
  input logic              rst,
  hazard_ctrl_unit_if.slave hz
);

  if ((MUL_LATENCY < 1) || (MUL_LATENCY > 16)) begin : g_bad_latency
    $error("hazard_ctrl_unit: MUL_LATENCY must be in 1..16");
  end

  // A single-cycle multiplier never needs to hold the pipe
  localparam bit              MULTI    = (MUL_LATENCY > 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(MUL_LATENCY - 1);

  mul_state_e       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  logic [1:0] fwd_a_raw;
  logic [1:0] fwd_b_raw;
  logic       mul_go;
  logic       mul_hold;
  logic       mul_last;
  logic       load_use;

  fwd_select #(.REG_ADDR_W(REG_ADDR_W)) u_fwd_a (
    .rs_ex         (hz.rs1_ex),
    .rd_mem        (hz.rd_mem),
    .reg_write_mem (hz.reg_write_mem),
    .rd_wb         (hz.rd_wb),
    .reg_write_wb  (hz.reg_write_wb),
    .fwd           (fwd_a_raw)
  );

  fwd_select #(.REG_ADDR_W(REG_ADDR_W)) u_fwd_b (
    .rs_ex         (hz.rs2_ex),
    .rd_mem        (hz.rd_mem),
    .reg_write_mem (hz.reg_write_mem),
    .rd_wb         (hz.rd_wb),
    .reg_write_wb  (hz.reg_write_wb),
    .fwd           (fwd_b_raw)
  );

  // Hazard conditions; the multiply hold masks load-use since ID/EX then holds the multiply
  always_comb begin
    mul_go   = MULTI && (state_q == MUL_IDLE) && hz.mul_ex && hz.valid_ex;
    mul_hold = mul_go || ((state_q == MUL_BUSY) && (cnt_q > CNT_ONE));
    mul_last = ((state_q == MUL_BUSY) && (cnt_q == CNT_ONE)) ||
               (!MULTI && hz.mul_ex && hz.valid_ex);
    load_use = hz.mem_read_ex && (hz.rd_ex != '0) &&
               ((hz.rd_ex == hz.rs1_id) || (hz.rd_ex == hz.rs2_id)) && !mul_hold;
  end

  // Next-state: count down the remaining EX cycles, return to IDLE on the last one
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      MUL_IDLE: begin
        if (mul_go) begin
          state_d = MUL_BUSY;
          cnt_d   = CNT_LOAD;
        end
      end
      MUL_BUSY: begin
        if (cnt_q > CNT_ONE) begin
          cnt_d = cnt_q - CNT_ONE;
        end else begin
          state_d = MUL_IDLE;
          cnt_d   = '0;
        end
      end
      default: begin
        state_d = MUL_IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  // FSM registers; reset abandons any multiply in flight
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= MUL_IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Drive controls; everything is forced quiet while reset is held
  always_comb begin
    hz.fwd_a      = rst ? FWD_RF : fwd_a_raw;
    hz.fwd_b      = rst ? FWD_RF : fwd_b_raw;
    hz.stall_if   = !rst && (mul_hold || load_use);
    hz.stall_id   = !rst && (mul_hold || load_use);
    hz.stall_ex   = !rst && mul_hold;
    hz.flush_ex   = !rst && load_use;
    hz.bubble_mem = !rst && mul_hold;
    hz.mul_busy   = !rst && (state_q == MUL_BUSY);
    hz.mul_done   = !rst && mul_last;
  end

endmodule

// File: tb/tb_hazard_ctrl_unit.sv
// tb/tb_hazard_ctrl_unit.sv - directed self-checking bench for hazard_ctrl_unit
module tb_hazard_ctrl_unit;

  logic clk;
  logic rst;
  int   n_checks;
  int   n_fail;

  hazard_ctrl_unit_if #(.REG_ADDR_W(5)) bus3 ();
  hazard_ctrl_unit_if #(.REG_ADDR_W(5)) bus1 ();

  hazard_ctrl_unit #(.REG_ADDR_W(5), .MUL_LATENCY(3)) dut3 (
    .clk (clk),
    .rst (rst),
    .hz  (bus3.slave)
  );

  hazard_ctrl_unit #(.REG_ADDR_W(5), .MUL_LATENCY(1)) dut1 (
    .clk (clk),
    .rst (rst),
    .hz  (bus1.slave)
  );

  // {stall_if, stall_id, stall_ex, flush_ex, bubble_mem, mul_busy, mul_done}
  logic [6:0] ctl3;
  logic [6:0] ctl1;
  assign ctl3 = {bus3.stall_if, bus3.stall_id, bus3.stall_ex, bus3.flush_ex,
                 bus3.bubble_mem, bus3.mul_busy, bus3.mul_done};
  assign ctl1 = {bus1.stall_if, bus1.stall_id, bus1.stall_ex, bus1.flush_ex,
                 bus1.bubble_mem, bus1.mul_busy, bus1.mul_done};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic idle_inputs();
    bus3.rs1_id = '0; bus3.rs2_id = '0; bus3.rs1_ex = '0; bus3.rs2_ex = '0;
    bus3.rd_ex = '0; bus3.mem_read_ex = 1'b0; bus3.mul_ex = 1'b0; bus3.valid_ex = 1'b0;
    bus3.rd_mem = '0; bus3.reg_write_mem = 1'b0; bus3.rd_wb = '0; bus3.reg_write_wb = 1'b0;
    bus1.rs1_id = '0; bus1.rs2_id = '0; bus1.rs1_ex = '0; bus1.rs2_ex = '0;
    bus1.rd_ex = '0; bus1.mem_read_ex = 1'b0; bus1.mul_ex = 1'b0; bus1.valid_ex = 1'b0;
    bus1.rd_mem = '0; bus1.reg_write_mem = 1'b0; bus1.rd_wb = '0; bus1.reg_write_wb = 1'b0;
  endtask

  // Advance to mid-cycle so inputs settle well away from the edge
  task automatic next_cycle();
    @(posedge clk);
    #2;
  endtask

  task automatic test_reset();
    next_cycle();
    rst = 1'b1;
    bus3.mul_ex = 1'b1; bus3.valid_ex = 1'b1;
    bus3.mem_read_ex = 1'b1; bus3.rd_ex = 5'd3; bus3.rs1_id = 5'd3;
    bus3.rs1_ex = 5'd4; bus3.rd_mem = 5'd4; bus3.reg_write_mem = 1'b1;
    bus1.mul_ex = 1'b1; bus1.valid_ex = 1'b1;
    #2;
    n_checks++;
    if (ctl3 !== 7'b0000000) begin
      n_fail++; $display("FAIL reset_ctl3: got %b expected %b", ctl3, 7'b0000000);
    end
    n_checks++;
    if ({bus3.fwd_a, bus3.fwd_b} !== 4'b0000) begin
      n_fail++; $display("FAIL reset_fwd: got %b expected %b", {bus3.fwd_a, bus3.fwd_b}, 4'b0000);
    end
    n_checks++;
    if (ctl1 !== 7'b0000000) begin
      n_fail++; $display("FAIL reset_ctl1: got %b expected %b", ctl1, 7'b0000000);
    end
    next_cycle();
    rst = 1'b0;
    idle_inputs();
    #2;
    n_checks++;
    if (ctl3 !== 7'b0000000) begin
      n_fail++; $display("FAIL post_reset_idle: got %b expected %b", ctl3, 7'b0000000);
    end
  endtask

  task automatic test_forwarding();
    next_cycle();
    bus3.rs1_ex = 5'd5; bus3.rs2_ex = 5'd6;
    bus3.rd_mem = 5'd5; bus3.reg_write_mem = 1'b1;
    bus3.rd_wb = 5'd5; bus3.reg_write_wb = 1'b1;
    #2;
    n_checks++;
    if (bus3.fwd_a !== 2'b10) begin
      n_fail++; $display("FAIL fwd_both_match: got %b expected %b", bus3.fwd_a, 2'b10);
    end
    n_checks++;
    if (bus3.fwd_b !== 2'b00) begin
      n_fail++; $display("FAIL fwd_b_nomatch: got %b expected %b", bus3.fwd_b, 2'b00);
    end
    next_cycle();
    bus3.reg_write_mem = 1'b0;
    #2;
    n_checks++;
    if (bus3.fwd_a !== 2'b01) begin
      n_fail++; $display("FAIL fwd_wb_only: got %b expected %b", bus3.fwd_a, 2'b01);
    end
    next_cycle();
    bus3.rs1_ex = 5'd0; bus3.rd_mem = 5'd0; bus3.rd_wb = 5'd0;
    bus3.reg_write_mem = 1'b1; bus3.reg_write_wb = 1'b1;
    #2;
    n_checks++;
    if (bus3.fwd_a !== 2'b00) begin
      n_fail++; $display("FAIL fwd_x0: got %b expected %b", bus3.fwd_a, 2'b00);
    end
    next_cycle();
    bus3.rs1_ex = 5'd7; bus3.rs2_ex = 5'd6;
    bus3.rd_mem = 5'd7; bus3.reg_write_mem = 1'b1;
    bus3.rd_wb = 5'd6; bus3.reg_write_wb = 1'b1;
    #2;
    n_checks++;
    if ({bus3.fwd_a, bus3.fwd_b} !== 4'b1001) begin
      n_fail++; $display("FAIL fwd_split: got %b expected %b", {bus3.fwd_a, bus3.fwd_b}, 4'b1001);
    end
    next_cycle();
    bus3.rs1_ex = 5'd9; bus3.rd_mem = 5'd9; bus3.rd_wb = 5'd9;
    bus3.reg_write_mem = 1'b0; bus3.reg_write_wb = 1'b0;
    #2;
    n_checks++;
    if (bus3.fwd_a !== 2'b00) begin
      n_fail++; $display("FAIL fwd_no_write: got %b expected %b", bus3.fwd_a, 2'b00);
    end
    idle_inputs();
  endtask

  task automatic test_load_use();
    next_cycle();
    bus3.mem_read_ex = 1'b1; bus3.rd_ex = 5'd7; bus3.rs2_id = 5'd7; bus3.rs1_id = 5'd2;
    #2;
    n_checks++;
    if (ctl3 !== 7'b1101000) begin
      n_fail++; $display("FAIL load_use_rs2: got %b expected %b", ctl3, 7'b1101000);
    end
    next_cycle();
    bus3.rd_ex = 5'd0; bus3.rs2_id = 5'd0;
    #2;
    n_checks++;
    if (ctl3 !== 7'b0000000) begin
      n_fail++; $display("FAIL load_use_x0: got %b expected %b", ctl3, 7'b0000000);
    end
    next_cycle();
    bus3.rd_ex = 5'd12; bus3.rs1_id = 5'd12; bus3.rs2_id = 5'd3;
    #2;
    n_checks++;
    if (ctl3 !== 7'b1101000) begin
      n_fail++; $display("FAIL load_use_rs1: got %b expected %b", ctl3, 7'b1101000);
    end
    next_cycle();
    bus3.mem_read_ex = 1'b0;
    #2;
    n_checks++;
    if (ctl3 !== 7'b0000000) begin
      n_fail++; $display("FAIL not_a_load: got %b expected %b", ctl3, 7'b0000000);
    end
    idle_inputs();
  endtask

  task automatic test_mul_invalid();
    for (int i = 0; i < 2; i++) begin
      next_cycle();
      bus3.mul_ex = 1'b1; bus3.valid_ex = 1'b0;
      #2;
      n_checks++;
      if (ctl3 !== 7'b0000000) begin
        n_fail++; $display("FAIL mul_invalid[%0d]: got %b expected %b", i, ctl3, 7'b0000000);
      end
    end
    idle_inputs();
  endtask

  task automatic test_mul_single();
    logic [6:0] exp_seq [4];
    exp_seq[0] = 7'b1110100;
    exp_seq[1] = 7'b1110110;
    exp_seq[2] = 7'b0000011;
    exp_seq[3] = 7'b0000000;
    for (int i = 0; i < 4; i++) begin
      next_cycle();
      bus3.mul_ex = (i == 0); bus3.valid_ex = (i == 0);
      #2;
      n_checks++;
      if (ctl3 !== exp_seq[i]) begin
        n_fail++; $display("FAIL mul_single[T+%0d]: got %b expected %b", i, ctl3, exp_seq[i]);
      end
    end
    idle_inputs();
  endtask

  task automatic test_back_to_back();
    logic [6:0] exp_seq [7];
    exp_seq[0] = 7'b1110100;
    exp_seq[1] = 7'b1110110;
    exp_seq[2] = 7'b0000011;
    exp_seq[3] = 7'b1110100;
    exp_seq[4] = 7'b1110110;
    exp_seq[5] = 7'b0000011;
    exp_seq[6] = 7'b0000000;
    for (int i = 0; i < 7; i++) begin
      next_cycle();
      bus3.mul_ex = (i < 6); bus3.valid_ex = (i < 6);
      #2;
      n_checks++;
      if (ctl3 !== exp_seq[i]) begin
        n_fail++; $display("FAIL back_to_back[%0d]: got %b expected %b", i + 1, ctl3, exp_seq[i]);
      end
    end
    idle_inputs();
  endtask

  task automatic test_rst_mid_mul();
    next_cycle();
    bus3.mul_ex = 1'b1; bus3.valid_ex = 1'b1;
    #2;
    n_checks++;
    if (ctl3 !== 7'b1110100) begin
      n_fail++; $display("FAIL rst_mul_entry: got %b expected %b", ctl3, 7'b1110100);
    end
    next_cycle();
    bus3.mul_ex = 1'b0; bus3.valid_ex = 1'b0;
    rst = 1'b1;
    #2;
    n_checks++;
    if (ctl3 !== 7'b0000000) begin
      n_fail++; $display("FAIL rst_during_busy: got %b expected %b", ctl3, 7'b0000000);
    end
    for (int i = 0; i < 2; i++) begin
      next_cycle();
      rst = 1'b0;
      #2;
      n_checks++;
      if (ctl3 !== 7'b0000000) begin
        n_fail++; $display("FAIL rst_abandon[%0d]: got %b expected %b", i, ctl3, 7'b0000000);
      end
    end
    idle_inputs();
  endtask

  task automatic test_mul_lat1();
    next_cycle();
    bus1.mul_ex = 1'b1; bus1.valid_ex = 1'b1;
    #2;
    n_checks++;
    if (ctl1 !== 7'b0000001) begin
      n_fail++; $display("FAIL lat1_entry: got %b expected %b", ctl1, 7'b0000001);
    end
    next_cycle();
    bus1.mul_ex = 1'b1; bus1.valid_ex = 1'b0;
    #2;
    n_checks++;
    if (ctl1 !== 7'b0000000) begin
      n_fail++; $display("FAIL lat1_after: got %b expected %b", ctl1, 7'b0000000);
    end
    idle_inputs();
  endtask

  task automatic test_load_after_mul();
    next_cycle();
    bus3.mul_ex = 1'b1; bus3.valid_ex = 1'b1;
    #2;
    n_checks++;
    if (ctl3 !== 7'b1110100) begin
      n_fail++; $display("FAIL lam_entry: got %b expected %b", ctl3, 7'b1110100);
    end
    next_cycle();
    bus3.mem_read_ex = 1'b1; bus3.rd_ex = 5'd9; bus3.rs1_id = 5'd9;
    #2;
    n_checks++;
    if (ctl3 !== 7'b1110110) begin
      n_fail++; $display("FAIL lam_suppressed: got %b expected %b", ctl3, 7'b1110110);
    end
    next_cycle();
    bus3.mul_ex = 1'b0;
    #2;
    n_checks++;
    if (ctl3 !== 7'b1101011) begin
      n_fail++; $display("FAIL lam_done_and_load: got %b expected %b", ctl3, 7'b1101011);
    end
    next_cycle();
    idle_inputs();
    #2;
    n_checks++;
    if (ctl3 !== 7'b0000000) begin
      n_fail++; $display("FAIL lam_idle: got %b expected %b", ctl3, 7'b0000000);
    end
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    rst      = 1'b1;
    idle_inputs();
    test_reset();
    test_forwarding();
    test_load_use();
    test_mul_invalid();
    test_mul_single();
    test_back_to_back();
    test_rst_mid_mul();
    test_mul_lat1();
    test_load_after_mul();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
